// File: rtl/instruction_sequencer.sv
// instruction_sequencer: host-loaded program memory that streams one 32-bit
// instruction per clock into the cpu, inserting NOP whenever nothing issues.
// Optional build macro: SEQUENCER_LOOP_EN (wrap pc and run until aborted).
module instruction_sequencer #(
   parameter int unsigned DEPTH    = 64,
   parameter logic [31:0] NOP_WORD = 32'h0000_0008,
   localparam int unsigned AW      = $clog2(DEPTH),
   localparam int unsigned LW      = AW + 1
) (
   input  logic          clock_in,
   input  logic          reset_in,
   input  logic          load_valid_in,
   input  logic [31:0]   load_data_in,
   input  logic          load_clear_in,
   input  logic          start_in,
   input  logic          stall_in,
   input  logic          abort_in,
   output logic [31:0]   current_instruction_out,
   output logic [AW-1:0] pc_out,
   output logic [LW-1:0] program_length_out,
   output logic          busy_out,
   output logic          done_out,
   output logic          load_overflow_out,
   output logic [15:0]   issued_count_out
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

   state_e        state_q, state_d;
   logic [31:0]   instr_q, instr_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [LW-1:0] len_q, len_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          last_q, last_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          mem_we;
   logic          is_last;
   logic [31:0]   mem_q [DEPTH];

   // The word at pc is the final word of the program.
   assign is_last = ((LW'(pc_q) + LW'(1)) == len_q);

   // Next-state and datapath decisions; every target defaults to hold or NOP.
   always_comb begin
      state_d = state_q;
      instr_d = NOP_WORD;
      pc_d    = pc_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      last_d  = last_q;
      mem_we  = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (load_clear_in) begin
               len_d   = '0;
               ovf_d   = 1'b0;
               state_d = ST_IDLE;
            end else if (start_in) begin
               pc_d    = '0;
               cnt_d   = '0;
               last_d  = 1'b0;
               state_d = (len_q == '0) ? ST_DONE : ST_RUN;
            end else if (load_valid_in) begin
               if (len_q == LW'(DEPTH)) begin
                  ovf_d = 1'b1;
               end else begin
                  mem_we = 1'b1;
                  len_d  = len_q + LW'(1);
               end
            end
         end
         ST_RUN: begin
            if (abort_in) begin
               state_d = ST_IDLE;
               pc_d    = '0;
               last_d  = 1'b0;
            end else if (last_q) begin
               state_d = ST_DONE;
               last_d  = 1'b0;
            end else if (!stall_in) begin
               instr_d = mem_q[pc_q];
               if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`ifdef SEQUENCER_LOOP_EN
               pc_d = is_last ? '0 : pc_q + AW'(1);
`else
               // pc wraps modulo DEPTH when a full program finishes
               pc_d   = pc_q + AW'(1);
               last_d = is_last;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q <= ST_IDLE;
         instr_q <= NOP_WORD;
         pc_q    <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Program memory write port; contents survive reset.
   always_ff @(posedge clock_in) begin
      if (mem_we && !reset_in) mem_q[AW'(len_q)] <= load_data_in;
   end

   assign current_instruction_out = instr_q;
   assign pc_out                  = pc_q;
   assign program_length_out      = len_q;
   assign busy_out                = busy_q;
   assign done_out                = done_q;
   assign load_overflow_out       = ovf_q;
   assign issued_count_out        = cnt_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer with a queue-based reference.
module tb_instruction_sequencer;

   localparam logic [31:0] NOP = 32'h0000_0008;
   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset_in = 1'b1;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = '0;
   logic        load_clear = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] instr;
   logic [5:0]  pc;
   logic [6:0]  len;
   logic        busy, done, ovf;
   logic [15:0] cnt;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   logic [31:0] mdl_mem [DEPTH];
   int          mdl_len = 0;
   bit          mdl_ovf = 0;

   instruction_sequencer dut (
      .clock_in(clk), .reset_in(reset_in),
      .load_valid_in(load_valid), .load_data_in(load_data),
      .load_clear_in(load_clear), .start_in(start),
      .stall_in(stall), .abort_in(abort),
      .current_instruction_out(instr), .pc_out(pc),
      .program_length_out(len), .busy_out(busy), .done_out(done),
      .load_overflow_out(ovf), .issued_count_out(cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [31:0] w);
      load_valid = 1'b1;
      load_data  = w;
      step();
      load_valid = 1'b0;
      if (mdl_len < DEPTH) begin
         mdl_mem[mdl_len] = w;
         mdl_len++;
      end else begin
         mdl_ovf = 1'b1;
      end
   endtask

   task automatic clear_prog();
      load_clear = 1'b1;
      step();
      load_clear = 1'b0;
      mdl_len = 0;
      mdl_ovf = 1'b0;
      chk("clear_len", 32'(len), 0);
      chk("clear_ovf", 32'(ovf), 0);
   endtask

   // Start the loaded program and follow it to DONE with random stalls.
   task automatic run_prog(input int unsigned stall_pct);
      logic [31:0] q[$];
      logic [31:0] w;
      int          issued;
      bit          fin;
      bit          st;
      issued = 0;
      fin = 1'b0;
      for (int i = 0; i < mdl_len; i++) q.push_back(mdl_mem[i]);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_out", instr, NOP);
      chk("start_busy", 32'(busy), 1);
      chk("start_done", 32'(done), 0);
      for (int cyc = 0; cyc < 4 * mdl_len + 8 && !fin; cyc++) begin
         st = (q.size() > 0) && ($urandom_range(99) < stall_pct);
         stall = st;
         step();
         stall = 1'b0;
         if (q.size() == 0) begin
            chk("end_out", instr, NOP);
            chk("end_done", 32'(done), 1);
            chk("end_busy", 32'(busy), 0);
            chk("end_count", 32'(cnt), 32'(issued));
            chk("end_pc", 32'(pc), 32'(mdl_len % DEPTH));
            fin = 1'b1;
         end else if (st) begin
            chk("stall_out", instr, NOP);
         end else begin
            w = q.pop_front();
            issued++;
            chk("issue_out", instr, w);
         end
      end
      if (!fin) chk("run_timeout", 0, 1);
   endtask

   initial begin
      // reset state
      step();
      step();
      reset_in = 1'b0;
      chk("rst_out", instr, NOP);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_len", 32'(len), 0);
      chk("rst_flags", {29'd0, busy, done, ovf}, 0);
      chk("rst_cnt", 32'(cnt), 0);

`ifdef SEQUENCER_LOOP_EN
      // looping program X, Y repeats until aborted
      load_word(32'hAAAA_0001);
      load_word(32'hBBBB_0002);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("loop_start", instr, NOP);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("loop_out", instr, mdl_mem[i % 2]);
         chk("loop_done", 32'(done), 0);
         chk("loop_busy", 32'(busy), 1);
      end
      chk("loop_cnt", 32'(cnt), 5);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("loop_abort_out", instr, NOP);
      chk("loop_abort_busy", 32'(busy), 0);
      chk("loop_abort_done", 32'(done), 0);
      chk("loop_abort_pc", 32'(pc), 0);
`else
      // directed three-word program, no stalls
      load_word(32'h0102_0300);
      load_word(32'h0003_0409);
      load_word(32'h0000_000F);
      chk("len3", 32'(len), 3);
      run_prog(0);

      // stall on the cycle B would issue
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("st_a", instr, 32'h0102_0300);
      stall = 1'b1;
      step();
      stall = 1'b0;
      chk("st_nop", instr, NOP);
      chk("st_pc", 32'(pc), 1);
      step();
      chk("st_b", instr, 32'h0003_0409);
      step();
      chk("st_c", instr, 32'h0000_000F);
      step();
      chk("st_end", instr, NOP);
      chk("st_done", 32'(done), 1);
      chk("st_cnt", 32'(cnt), 3);

      // random programs with random stalls
      for (int t = 0; t < 6; t++) begin
         int n;
         clear_prog();
         n = int'($urandom_range(8, 1));
         for (int i = 0; i < n; i++) load_word($urandom());
         chk("rnd_len", 32'(len), 32'(mdl_len));
         run_prog(30);
      end

      // overflow: DEPTH+1 words
      clear_prog();
      for (int i = 0; i <= DEPTH; i++) load_word(32'h5A00_0000 | 32'(i));
      chk("ovf_len", 32'(len), 64);
      chk("ovf_flag", 32'(ovf), 32'(mdl_ovf));
      run_prog(0);
      clear_prog();

      // start with empty program
      start = 1'b1;
      step();
      start = 1'b0;
      chk("empty_done", 32'(done), 1);
      chk("empty_busy", 32'(busy), 0);
      chk("empty_out", instr, NOP);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("empty_hold_busy", 32'(busy), 0);
         chk("empty_hold_out", instr, NOP);
      end

      // abort while issuing word 1
      load_word(32'h1111_0000);
      load_word(32'h2222_0000);
      load_word(32'h3333_0000);
      chk("ld_in_done", 32'(done), 1);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("ab_w0", instr, 32'h1111_0000);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_out", instr, NOP);
      chk("ab_busy", 32'(busy), 0);
      chk("ab_done", 32'(done), 0);
      chk("ab_pc", 32'(pc), 0);

      // reset mid-run
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("pre_rst_busy", 32'(busy), 1);
      reset_in = 1'b1;
      step();
      reset_in = 1'b0;
      chk("mrst_out", instr, NOP);
      chk("mrst_pc", 32'(pc), 0);
      chk("mrst_len", 32'(len), 0);
      chk("mrst_flags", {29'd0, busy, done, ovf}, 0);
      chk("mrst_cnt", 32'(cnt), 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
